// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer feeding the register-file/ALU/RAM datapath.
// Optional retired-instruction counter enabled by SEQ_RETIRE_CNT_EN.
module datapath_sequencer #(
    parameter int                DATA_W   = 64,
    parameter int                REG_AW   = 5,
    parameter int                FS_W     = 5,
    parameter logic [FS_W-1:0]   ADDR_FS  = 5'd0,
    parameter int                ZERO_REG = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [REG_AW-1:0] A,
    output logic [REG_AW-1:0] B,
    output logic [REG_AW-1:0] regSel,
    output logic [FS_W-1:0]   FS,
    output logic              CO,
    output logic              wrt,
    output logic              RAMwrt,
    output logic              muxSelect,
    output logic [DATA_W-1:0] in,
    output logic              done,
    output logic [31:0]       retired_cnt
);

    // state | meaning
    // IDLE  | waiting for an instruction, instr_ready high
    // EXEC  | operands on A/B, ALU computing result or address
    // MEM   | RAM access (STORE writes here and completes)
    // WB    | register-file writeback, instruction completes
    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    localparam logic [1:0] T_ALU   = 2'b00;
    localparam logic [1:0] T_LOAD  = 2'b01;
    localparam logic [1:0] T_STORE = 2'b10;
    localparam logic [1:0] T_LOADI = 2'b11;

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    state_t state, state_nx;

    logic [1:0]        type_q;
    logic [FS_W-1:0]   fs_q;
    logic [REG_AW-1:0] da_q, sa_q, sb_q;
    logic [9:0]        imm_q;

    logic accept;
    logic [FS_W-1:0] fs_sel;

    assign instr_ready = (state == IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;
    assign fs_sel      = (type_q == T_ALU) ? fs_q : ADDR_FS;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Fields are latched on accept so outputs never track instr afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            type_q <= '0;
            fs_q   <= '0;
            da_q   <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            imm_q  <= '0;
        end else if (accept) begin
            type_q <= instr[31:30];
            fs_q   <= FS_W'(instr[29:25]);
            da_q   <= REG_AW'(instr[24:20]);
            sa_q   <= REG_AW'(instr[19:15]);
            sb_q   <= REG_AW'(instr[14:10]);
            imm_q  <= instr[9:0];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (instr[31:30] == T_LOADI) ? WB : EXEC;
            EXEC: state_nx = (type_q == T_ALU) ? WB : MEM;
            MEM:  state_nx = (type_q == T_LOAD) ? WB : IDLE;
            WB:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        A         = '0;
        B         = '0;
        regSel    = '0;
        FS        = '0;
        CO        = 1'b0;
        wrt       = 1'b0;
        RAMwrt    = 1'b0;
        muxSelect = 1'b0;
        in        = '0;
        done      = 1'b0;
        case (state)
            EXEC: begin
                A  = sa_q;
                B  = sb_q;
                FS = fs_sel;
                CO = (type_q == T_ALU) && imm_q[0];
            end
            MEM: begin
                A      = sa_q;
                B      = sb_q;
                FS     = fs_sel;
                RAMwrt = (type_q == T_STORE);
                done   = (type_q == T_STORE);
            end
            WB: begin
                A         = sa_q;
                B         = sb_q;
                FS        = fs_sel;
                regSel    = da_q;
                wrt       = (da_q != ZERO_IDX);
                muxSelect = (type_q == T_LOAD);
                in        = (type_q == T_LOADI) ? DATA_W'(imm_q) : '0;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SEQ_RETIRE_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
        end else if (done) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: per-cycle model comparison
// plus directed literal checks.
module tb_datapath_sequencer;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;
    localparam int FS_W   = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       instr = '0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [REG_AW-1:0] A, B, regSel;
    logic [FS_W-1:0]   FS;
    logic              CO, wrt, RAMwrt, muxSelect, done;
    logic [DATA_W-1:0] in;
    logic [31:0]       retired_cnt;

    int n_checks = 0;
    int n_errors = 0;

    datapath_sequencer dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .A(A), .B(B), .regSel(regSel), .FS(FS),
        .CO(CO), .wrt(wrt), .RAMwrt(RAMwrt), .muxSelect(muxSelect), .in(in),
        .done(done), .retired_cnt(retired_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        ready;
        logic [4:0]  a, b, rsel, fs;
        logic        co, wrt, ramwrt, mux;
        logic [63:0] in;
        logic        done;
        logic [31:0] cnt;
    } outs_t;

    // Model: an instruction is a list of stages whose length depends on type.
    logic        m_busy = 1'b0;
    int          m_k = 0;
    logic [31:0] m_ins = '0;
    logic [31:0] m_cnt = '0;

    function automatic int len_of(logic [1:0] t);
        case (t)
            2'b00: return 2;
            2'b01: return 3;
            2'b10: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic outs_t model_out(logic rst, logic busy, logic [31:0] ins, int k, logic [31:0] cnt);
        outs_t o;
        logic [1:0] t;
        int len;
        logic is_exec, is_mem, is_wb;
        o = '0;
        t = ins[31:30];
        len = len_of(t);
`ifdef SEQ_RETIRE_CNT_EN
        o.cnt = cnt;
`endif
        if (rst) return o;
        if (!busy) begin
            o.ready = 1'b1;
            return o;
        end
        is_exec = (t != 2'b11) && (k == 1);
        is_mem  = (t == 2'b01 || t == 2'b10) && (k == 2);
        is_wb   = (t != 2'b10) && (k == len);
        o.a      = ins[19:15];
        o.b      = ins[14:10];
        o.fs     = (t == 2'b00) ? ins[29:25] : 5'd0;
        o.co     = is_exec && (t == 2'b00) && ins[0];
        o.rsel   = is_wb ? ins[24:20] : 5'd0;
        o.wrt    = is_wb && (ins[24:20] != 5'd31);
        o.ramwrt = is_mem && (t == 2'b10);
        o.mux    = is_wb && (t == 2'b01);
        o.in     = (is_wb && t == 2'b11) ? {54'd0, ins[9:0]} : 64'd0;
        o.done   = (k == len);
        return o;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_cnt  <= '0;
        end else if (m_busy) begin
            if (m_k == len_of(m_ins[31:30])) begin
                m_busy <= 1'b0;
                m_cnt  <= m_cnt + 32'd1;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (instr_valid) begin
            m_busy <= 1'b1;
            m_ins  <= instr;
            m_k    <= 1;
        end
    end

    always @(negedge clock) begin
        outs_t exp_o, act_o;
        exp_o = model_out(reset, m_busy, m_ins, m_k, m_cnt);
        act_o = {instr_ready, A, B, regSel, FS, CO, wrt, RAMwrt, muxSelect, in, done, retired_cnt};
        n_checks++;
        if (act_o !== exp_o) begin
            n_errors++;
            $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, act_o, exp_o);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] mk(logic [1:0] t, logic [4:0] fs, logic [4:0] da,
                                       logic [4:0] sa, logic [4:0] sb, logic [9:0] imm);
        return {t, fs, da, sa, sb, imm};
    endfunction

    // Returns in cycle 1 of the instruction (just after its accept edge).
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        @(posedge clock); #2;
        while (m_busy && n < 20) begin
            @(posedge clock); #2;
            n++;
        end
        if (n == 20) begin
            n_errors++;
            $display("FAIL idle_timeout got=busy expected=idle");
        end
        instr = w;
        instr_valid = 1'b1;
        @(posedge clock); #2;
        instr_valid = 1'b0;
        instr = $urandom;
    endtask

    task automatic next_neg();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 20) begin
            @(posedge clock); #2;
            n++;
        end
        if (n == 20) begin
            n_errors++;
            $display("FAIL idle_timeout got=busy expected=idle");
        end
    endtask

    initial begin
        #1;
        reset = 1'b1;
        instr_valid = 1'b1;
        instr = mk(2'b00, 5'd3, 5'd4, 5'd1, 5'd2, 10'd1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 64'(instr_ready), 64'd0);
        chk("rst_in", in, 64'd0);
        chk("rst_A", 64'(A), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cnt", 64'(retired_cnt), 64'd0);
        @(posedge clock); #2;
        instr_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 64'(instr_ready), 64'd1);

        send(mk(2'b00, 5'd3, 5'd4, 5'd1, 5'd2, 10'd1));
        @(negedge clock);
        chk("alu_c1_A", 64'(A), 64'd1);
        chk("alu_c1_B", 64'(B), 64'd2);
        chk("alu_c1_FS", 64'(FS), 64'd3);
        chk("alu_c1_CO", 64'(CO), 64'd1);
        next_neg();
        chk("alu_c2_regSel", 64'(regSel), 64'd4);
        chk("alu_c2_wrt", 64'(wrt), 64'd1);
        chk("alu_c2_mux", 64'(muxSelect), 64'd0);
        chk("alu_c2_done", 64'(done), 64'd1);
        next_neg();
        chk("alu_c3_ready", 64'(instr_ready), 64'd1);

        send(mk(2'b01, 5'd9, 5'd7, 5'd5, 5'd0, 10'd0));
        @(negedge clock);
        chk("ld_c1_FS", 64'(FS), 64'd0);
        chk("ld_c1_A", 64'(A), 64'd5);
        chk("ld_c1_wrt", 64'(wrt), 64'd0);
        next_neg();
        chk("ld_c2_FS", 64'(FS), 64'd0);
        chk("ld_c2_A", 64'(A), 64'd5);
        chk("ld_c2_wrt", 64'(wrt), 64'd0);
        next_neg();
        chk("ld_c3_wrt", 64'(wrt), 64'd1);
        chk("ld_c3_regSel", 64'(regSel), 64'd7);
        chk("ld_c3_mux", 64'(muxSelect), 64'd1);
        chk("ld_c3_done", 64'(done), 64'd1);

        send(mk(2'b10, 5'd4, 5'd2, 5'd3, 5'd9, 10'd5));
        @(negedge clock);
        chk("st_c1_ramwrt", 64'(RAMwrt), 64'd0);
        next_neg();
        chk("st_c2_ramwrt", 64'(RAMwrt), 64'd1);
        chk("st_c2_A", 64'(A), 64'd3);
        chk("st_c2_B", 64'(B), 64'd9);
        chk("st_c2_wrt", 64'(wrt), 64'd0);
        chk("st_c2_done", 64'(done), 64'd1);

        send(mk(2'b11, 5'd7, 5'd31, 5'd0, 5'd0, 10'h3FF));
        @(negedge clock);
        chk("ldi31_in", in, 64'h3FF);
        chk("ldi31_wrt", 64'(wrt), 64'd0);
        chk("ldi31_done", 64'(done), 64'd1);

        send(mk(2'b11, 5'd0, 5'd6, 5'd0, 5'd0, 10'h155));
        @(negedge clock);
        chk("ldi6_wrt", 64'(wrt), 64'd1);
        chk("ldi6_in", in, 64'h155);

        send(mk(2'b00, 5'd12, 5'd31, 5'd8, 5'd9, 10'd0));

        // Valid held high with a changing word: only accept-edge words matter.
        wait_idle();
        for (int i = 0; i < 12; i++) begin
            instr = mk(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom),
                       5'($urandom), 5'($urandom), 10'($urandom));
            instr_valid = 1'b1;
            @(posedge clock); #2;
        end
        instr_valid = 1'b0;
        wait_idle();

        send(mk(2'b01, 5'd0, 5'd7, 5'd5, 5'd1, 10'd0));
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("midrst_wrt", 64'(wrt), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_ready", 64'(instr_ready), 64'd0);
        chk("midrst_A", 64'(A), 64'd0);
        chk("midrst_cnt", 64'(retired_cnt), 64'd0);
        @(posedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_idle_ready", 64'(instr_ready), 64'd1);
        chk("midrst_after_wrt", 64'(wrt), 64'd0);

        send(mk(2'b00, 5'd1, 5'd2, 5'd3, 5'd4, 10'd0));
        send(mk(2'b10, 5'd0, 5'd0, 5'd1, 5'd2, 10'd0));
        send(mk(2'b11, 5'd0, 5'd3, 5'd0, 5'd0, 10'd77));
        wait_idle();
        @(negedge clock);
`ifdef SEQ_RETIRE_CNT_EN
        chk("retired_3", 64'(retired_cnt), 64'd3);
`else
        chk("retired_off", 64'(retired_cnt), 64'd0);
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
